// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the arbitrated repeated-addition multiplier:
//   WIDTH   - operand / product width of the shared datapath
//   state_t - controller state encoding (IDLE, LDA, LDB, ADD, DONE)
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDA  = 3'd1,
        ST_LDB  = 3'd2,
        ST_ADD  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_arbiter_if
// Bundles the requester handshake and the datapath control bus.
//   slave  modport - seen by the arbiter/controller (mul_arbiter)
//   master modport - seen by the requesters and the datapath
// Signals:
//   req0/req1, a0/b0/a1/b1   requests and operands
//   done0/done1, result      completion pulses and held product
//   busy, gnt_id             controller status
//   data_out, lda, ldb, ldp, clrp, decb   datapath operand bus and strobes
//   eqz, p_in                datapath B==0 flag and product register
// ---------------------------------------------------------------------------
interface mul_arbiter_if #(
    parameter int WIDTH = mul_pkg::WIDTH
);

    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             gnt_id;
    logic [WIDTH-1:0] data_out;
    logic             lda;
    logic             ldb;
    logic             ldp;
    logic             clrp;
    logic             decb;
    logic             eqz;
    logic [WIDTH-1:0] p_in;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, eqz, p_in,
        output done0, done1, result, busy, gnt_id,
        output data_out, lda, ldb, ldp, clrp, decb
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, eqz, p_in,
        input  done0, done1, result, busy, gnt_id,
        input  data_out, lda, ldb, ldp, clrp, decb
    );

endinterface

// File: rtl/mul_datapath.sv
// ---------------------------------------------------------------------------
// mul_datapath
// Repeated-addition multiplier datapath: A, B and P registers.
//   clk            - rising-edge clock (no reset; contents are re-initialised
//                    by each job's load / clear strobes)
//   data_i         - operand bus
//   lda_i, ldb_i   - load A / load B from data_i
//   ldp_i          - P <= P + A
//   clrp_i         - P <= 0
//   decb_i         - B <= B - 1
//   eqz_o          - B == 0 (combinational)
//   p_o            - product register P
// ---------------------------------------------------------------------------
module mul_datapath #(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] data_i,
    input  logic             lda_i,
    input  logic             ldb_i,
    input  logic             ldp_i,
    input  logic             clrp_i,
    input  logic             decb_i,
    output logic             eqz_o,
    output logic [WIDTH-1:0] p_o
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_q;

    always_ff @(posedge clk) begin
        if (lda_i) begin
            a_q <= data_i;
        end
        if (ldb_i) begin
            b_q <= data_i;
        end else if (decb_i) begin
            b_q <= b_q - 1'b1;
        end
        // Sum wraps modulo 2^WIDTH; overflow is simply dropped.
        if (clrp_i) begin
            p_q <= '0;
        end else if (ldp_i) begin
            p_q <= p_q + a_q;
        end
    end

    assign eqz_o = (b_q == '0);
    assign p_o   = p_q;

endmodule

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin selector (purely combinational).
//   req0_i, req1_i - request levels
//   last_i         - index of the requester served last
//   valid_o        - at least one request present
//   idx_o          - index of the winning requester
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic idx_o
);

    // On a tie the requester that was not served last wins; otherwise the
    // sole requester wins (idx defaults to 0 when nobody requests).
    assign valid_o = req0_i | req1_i;
    assign idx_o   = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Shares one repeated-addition multiplier datapath between two requesters
// with round-robin arbitration.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mul_arbiter_if.slave: requests/operands in, done/result/status
//         out, datapath operand bus and strobes out, eqz/p_in back in
// ---------------------------------------------------------------------------
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    mul_arbiter_if.slave bus
);

    state_t           state_q;
    logic             last_q;
    logic             gnt_q;
    logic             busy_q;
    logic             done0_q;
    logic             done1_q;
    logic             lda_q;
    logic             ldb_q;
    logic             clrp_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] data_q;

    logic             gnt_valid;
    logic             gnt_idx;

    rr_arbiter2 u_rr (
        .req0_i  (bus.req0),
        .req1_i  (bus.req1),
        .last_i  (last_q),
        .valid_o (gnt_valid),
        .idx_o   (gnt_idx)
    );

    // Controller FSM. Strobes, data bus and done pulses are registered and
    // set up on the edge that enters the state they belong to, so they are
    // default-cleared every cycle. last_q resets to 1 so that requester 0
    // wins the first tie. The A operand goes straight into data_q on grant;
    // B is held in opb_q until LDB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            busy_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            lda_q    <= 1'b0;
            ldb_q    <= 1'b0;
            clrp_q   <= 1'b0;
            opb_q    <= '0;
            result_q <= '0;
            data_q   <= '0;
        end else begin
            lda_q   <= 1'b0;
            ldb_q   <= 1'b0;
            clrp_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            data_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        data_q  <= gnt_idx ? bus.a1 : bus.a0;
                        opb_q   <= gnt_idx ? bus.b1 : bus.b0;
                        gnt_q   <= gnt_idx;
                        last_q  <= gnt_idx;
                        busy_q  <= 1'b1;
                        lda_q   <= 1'b1;
                        state_q <= ST_LDA;
                    end
                end
                ST_LDA: begin
                    ldb_q   <= 1'b1;
                    clrp_q  <= 1'b1;
                    data_q  <= opb_q;
                    state_q <= ST_LDB;
                end
                ST_LDB: begin
                    state_q <= ST_ADD;
                end
                ST_ADD: begin
                    if (bus.eqz) begin
                        result_q <= bus.p_in;
                        done0_q  <= ~gnt_q;
                        done1_q  <= gnt_q;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Add/decrement strobes react to eqz in the same cycle, which is what
    // gives exactly b strobes per job.
    assign bus.ldp      = (state_q == ST_ADD) & ~bus.eqz;
    assign bus.decb     = (state_q == ST_ADD) & ~bus.eqz;
    assign bus.lda      = lda_q;
    assign bus.ldb      = ldb_q;
    assign bus.clrp     = clrp_q;
    assign bus.data_out = data_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.result   = result_q;
    assign bus.busy     = busy_q;
    assign bus.gnt_id   = gnt_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
// Self-checking bench for mul_arbiter together with the multiplier datapath.
// Expected products, latencies, strobe counts and service order come from a
// behavioural model: product = a*b mod 65536, done in cycle b+4, b strobes,
// and round-robin winner = the requester not served last.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;

    logic clk;
    logic rst;

    int testsRun;
    int testsFailed;
    int modelLast;

    mul_arbiter_if #(.WIDTH(16)) bus ();

    mul_arbiter #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mul_datapath #(.WIDTH(16)) u_dp (
        .clk    (clk),
        .data_i (bus.data_out),
        .lda_i  (bus.lda),
        .ldb_i  (bus.ldb),
        .ldp_i  (bus.ldp),
        .clrp_i (bus.clrp),
        .decb_i (bus.decb),
        .eqz_o  (bus.eqz),
        .p_o    (bus.p_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modelProduct(input int a, input int b);
        return (a * b) % 65536;
    endfunction

    // Round-robin reference: the requester not served last wins a tie.
    function automatic int modelWinner(input bit r0, input bit r1, input int last);
        if (r0 && r1) return 1 - last;
        return r1 ? 1 : 0;
    endfunction

    // Observes one job, assuming the next rising edge is the IDLE sampling
    // edge. Cycle 1 is the first negedge after that edge. Records what was
    // seen; comparisons are made by the calling test.
    task automatic run_job(input bit keepReq, input bit scramble,
                           output int doneCyc, output int strobes, output int who,
                           output int gnt1, output int dA, output int dB,
                           output bit lda1, output bit ldbc2, output bit stray,
                           output int res);
        int  cyc;
        bit  fin;
        cyc = 0; fin = 0; strobes = 0; who = -1; gnt1 = -1;
        dA = -1; dB = -1; lda1 = 0; ldbc2 = 0; stray = 0; res = -1; doneCyc = -1;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (bus.ldp === 1'b1) strobes++;
            if (bus.ldp !== bus.decb) stray = 1;
            if (bus.busy !== 1'b1) stray = 1;
            if (cyc == 1) begin
                lda1 = (bus.lda === 1'b1);
                dA   = int'(bus.data_out);
                gnt1 = int'(bus.gnt_id);
                if (bus.ldb | bus.clrp | bus.ldp | bus.done0 | bus.done1) stray = 1;
                if (scramble) begin
                    if (gnt1 == 0) begin
                        bus.req0 = 1'b0; bus.a0 = 16'($urandom); bus.b0 = 16'($urandom);
                    end else begin
                        bus.req1 = 1'b0; bus.a1 = 16'($urandom); bus.b1 = 16'($urandom);
                    end
                end
            end else if (cyc == 2) begin
                ldbc2 = (bus.ldb === 1'b1) && (bus.clrp === 1'b1);
                dB    = int'(bus.data_out);
                if (bus.lda | bus.ldp | bus.done0 | bus.done1) stray = 1;
            end else begin
                if (bus.lda | bus.ldb | bus.clrp | (bus.data_out != 16'd0)) stray = 1;
            end
            if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
                fin     = 1;
                doneCyc = cyc;
                who     = (bus.done1 === 1'b1) ? 1 : 0;
                res     = int'(bus.result);
                if (bus.done0 === 1'b1 && bus.done1 === 1'b1) stray = 1;
                if (!keepReq) begin
                    if (who == 0) bus.req0 = 1'b0;
                    else          bus.req1 = 1'b0;
                end
            end else if (cyc >= 400) begin
                fin = 1;
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
    endtask

    task automatic applyReset();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelLast = 1;
    endtask

    task automatic test_reset();
        applyReset();
        testsRun += 5;
        if (bus.busy !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_busy: got %0b, expected 0", bus.busy);
        end
        if (bus.gnt_id !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_gnt: got %0b, expected 0", bus.gnt_id);
        end
        if (bus.result !== 16'd0) begin
            testsFailed++; $display("[TB] FAIL reset_result: got %0d, expected 0", bus.result);
        end
        if (bus.data_out !== 16'd0) begin
            testsFailed++; $display("[TB] FAIL reset_data: got %0d, expected 0", bus.data_out);
        end
        if ({bus.lda, bus.ldb, bus.ldp, bus.clrp, bus.decb, bus.done0, bus.done1} !== 7'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: got %b, expected 0000000",
                     {bus.lda, bus.ldb, bus.ldp, bus.clrp, bus.decb, bus.done0, bus.done1});
        end
    endtask

    task automatic test_basic();
        int dc, st, who, g, dA, dB, res; bit l1, l2, stray;
        @(negedge clk);
        bus.a0 = 16'd17; bus.b0 = 16'd5; bus.req0 = 1'b1;
        run_job(0, 0, dc, st, who, g, dA, dB, l1, l2, stray, res);
        modelLast = 0;
        testsRun += 7;
        if (!(l1 && dA == 17)) begin
            testsFailed++; $display("[TB] FAIL basic_lda: got lda=%0b data=%0d, expected lda=1 data=17", l1, dA);
        end
        if (!(l2 && dB == 5)) begin
            testsFailed++; $display("[TB] FAIL basic_ldb: got ldb&clrp=%0b data=%0d, expected 1 data=5", l2, dB);
        end
        if (st != 5) begin
            testsFailed++; $display("[TB] FAIL basic_strobes: got %0d, expected 5", st);
        end
        if (dc != 9) begin
            testsFailed++; $display("[TB] FAIL basic_latency: got %0d, expected 9", dc);
        end
        if (who != 0) begin
            testsFailed++; $display("[TB] FAIL basic_done_line: got %0d, expected 0", who);
        end
        if (res != modelProduct(17, 5)) begin
            testsFailed++; $display("[TB] FAIL basic_result: got %0d, expected %0d", res, modelProduct(17, 5));
        end
        if (stray) begin
            testsFailed++; $display("[TB] FAIL basic_stray_strobe: got 1, expected 0");
        end
    endtask

    task automatic test_zero();
        int dc, st, who, g, dA, dB, res; bit l1, l2, stray;
        @(negedge clk);
        bus.a1 = 16'd9; bus.b1 = 16'd0; bus.req1 = 1'b1;
        run_job(0, 0, dc, st, who, g, dA, dB, l1, l2, stray, res);
        modelLast = 1;
        testsRun += 4;
        if (st != 0) begin
            testsFailed++; $display("[TB] FAIL zero_strobes: got %0d, expected 0", st);
        end
        if (dc != 4) begin
            testsFailed++; $display("[TB] FAIL zero_latency: got %0d, expected 4", dc);
        end
        if (who != 1) begin
            testsFailed++; $display("[TB] FAIL zero_done_line: got %0d, expected 1", who);
        end
        if (res != 0 || stray) begin
            testsFailed++; $display("[TB] FAIL zero_result: got %0d stray=%0b, expected 0 stray=0", res, stray);
        end
    endtask

    task automatic test_simultaneous();
        int dc, st, who, g, dA, dB, res; bit l1, l2, stray;
        applyReset();
        @(negedge clk);
        bus.a0 = 16'd3; bus.b0 = 16'd4; bus.a1 = 16'd6; bus.b1 = 16'd7;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int j = 0; j < 2; j++) begin
            int expWho;
            int expRes;
            expWho = modelWinner(1'b1, (j == 0) || 1'b1, modelLast);
            if (j == 1) expWho = 1 - modelLast;
            expRes = (expWho == 0) ? modelProduct(3, 4) : modelProduct(6, 7);
            if (j == 1) @(negedge clk);
            run_job(0, 0, dc, st, who, g, dA, dB, l1, l2, stray, res);
            modelLast = expWho;
            testsRun += 3;
            if (who != expWho) begin
                testsFailed++; $display("[TB] FAIL simul_order%0d: got %0d, expected %0d", j, who, expWho);
            end
            if (g != expWho) begin
                testsFailed++; $display("[TB] FAIL simul_gnt%0d: got %0d, expected %0d", j, g, expWho);
            end
            if (res != expRes) begin
                testsFailed++; $display("[TB] FAIL simul_result%0d: got %0d, expected %0d", j, res, expRes);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc, st, who, g, dA, dB, res; bit l1, l2, stray;
        int ops [2][2];
        int served [2];
        served[0] = 0; served[1] = 0;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            ops[r][0] = int'($urandom_range(0, 65535));
            ops[r][1] = int'($urandom_range(0, 9));
        end
        bus.a0 = 16'(ops[0][0]); bus.b0 = 16'(ops[0][1]);
        bus.a1 = 16'(ops[1][0]); bus.b1 = 16'(ops[1][1]);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            int expWho;
            int expRes;
            expWho = modelWinner(1'b1, 1'b1, modelLast);
            expRes = modelProduct(ops[expWho][0], ops[expWho][1]);
            if (j != 0) @(negedge clk);
            run_job(1, 0, dc, st, who, g, dA, dB, l1, l2, stray, res);
            modelLast = expWho;
            if (who == 0 || who == 1) served[who]++;
            testsRun += 2;
            if (who != expWho) begin
                testsFailed++; $display("[TB] FAIL b2b_order%0d: got %0d, expected %0d", j, who, expWho);
            end
            if (res != expRes) begin
                testsFailed++; $display("[TB] FAIL b2b_result%0d: got %0d, expected %0d", j, res, expRes);
            end
            if (expWho == 0) begin
                ops[0][0] = int'($urandom_range(0, 65535)); ops[0][1] = int'($urandom_range(0, 9));
                bus.a0 = 16'(ops[0][0]); bus.b0 = 16'(ops[0][1]);
            end else begin
                ops[1][0] = int'($urandom_range(0, 65535)); ops[1][1] = int'($urandom_range(0, 9));
                bus.a1 = 16'(ops[1][0]); bus.b1 = 16'(ops[1][1]);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        testsRun++;
        if (served[0] != 2 || served[1] != 2) begin
            testsFailed++; $display("[TB] FAIL b2b_fairness: got %0d/%0d, expected 2/2", served[0], served[1]);
        end
    endtask

    task automatic test_overflow();
        int dc, st, who, g, dA, dB, res; bit l1, l2, stray;
        @(negedge clk);
        bus.a0 = 16'd300; bus.b0 = 16'd300; bus.req0 = 1'b1;
        run_job(0, 0, dc, st, who, g, dA, dB, l1, l2, stray, res);
        modelLast = 0;
        testsRun += 3;
        if (res != 24464) begin
            testsFailed++; $display("[TB] FAIL ovf_result: got %0d, expected 24464", res);
        end
        if (st != 300) begin
            testsFailed++; $display("[TB] FAIL ovf_strobes: got %0d, expected 300", st);
        end
        if (dc != 304) begin
            testsFailed++; $display("[TB] FAIL ovf_latency: got %0d, expected 304", dc);
        end
    endtask

    task automatic test_reset_mid_job();
        int dc, st, who, g, dA, dB, res; bit l1, l2, stray;
        bit sawActivity;
        int pa;
        int pb;
        @(negedge clk);
        bus.a0 = 16'($urandom_range(1, 1000)); bus.b0 = 16'd10; bus.req0 = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; bus.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        modelLast = 1;
        testsRun += 3;
        if ({bus.lda, bus.ldb, bus.ldp, bus.clrp, bus.decb, bus.done0, bus.done1} !== 7'd0) begin
            testsFailed++;
            $display("[TB] FAIL abort_strobes: got %b, expected 0000000",
                     {bus.lda, bus.ldb, bus.ldp, bus.clrp, bus.decb, bus.done0, bus.done1});
        end
        if (bus.busy !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL abort_busy: got %0b, expected 0", bus.busy);
        end
        if (bus.result !== 16'd0 || bus.gnt_id !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL abort_regs: got result=%0d gnt=%0b, expected 0/0", bus.result, bus.gnt_id);
        end
        sawActivity = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done0 | bus.done1 | bus.ldp | bus.busy) sawActivity = 1;
        end
        testsRun++;
        if (sawActivity) begin
            testsFailed++; $display("[TB] FAIL abort_no_done: got activity=1, expected 0");
        end
        pa = int'($urandom_range(0, 65535)); pb = int'($urandom_range(0, 8));
        bus.a0 = 16'(pa); bus.b0 = 16'(pb);
        bus.a1 = 16'd5; bus.b1 = 16'd6;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        run_job(0, 0, dc, st, who, g, dA, dB, l1, l2, stray, res);
        modelLast = 0;
        testsRun += 2;
        if (who != 0) begin
            testsFailed++; $display("[TB] FAIL abort_regrant: got %0d, expected 0", who);
        end
        if (res != modelProduct(pa, pb)) begin
            testsFailed++; $display("[TB] FAIL abort_result: got %0d, expected %0d", res, modelProduct(pa, pb));
        end
        @(negedge clk);
        run_job(0, 0, dc, st, who, g, dA, dB, l1, l2, stray, res);
        modelLast = 1;
        testsRun++;
        if (who != 1 || res != 30) begin
            testsFailed++; $display("[TB] FAIL abort_drain: got who=%0d res=%0d, expected 1/30", who, res);
        end
    endtask

    task automatic test_random();
        int dc, st, who, g, dA, dB, res; bit l1, l2, stray;
        for (int j = 0; j < 8; j++) begin
            int pat;
            int ops [2][2];
            int pending [$];
            pat = int'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                ops[r][0] = int'($urandom_range(0, 65535));
                ops[r][1] = int'($urandom_range(0, 12));
            end
            @(negedge clk);
            bus.a0 = 16'(ops[0][0]); bus.b0 = 16'(ops[0][1]);
            bus.a1 = 16'(ops[1][0]); bus.b1 = 16'(ops[1][1]);
            bus.req0 = pat[0]; bus.req1 = pat[1];
            if (pat == 3) begin
                pending.push_back(1 - modelLast);
                pending.push_back(modelLast);
            end else begin
                pending.push_back(pat[1] ? 1 : 0);
            end
            for (int k = 0; pending.size() > 0; k++) begin
                int expWho;
                int expRes;
                expWho = pending.pop_front();
                expRes = modelProduct(ops[expWho][0], ops[expWho][1]);
                if (k != 0) @(negedge clk);
                run_job(0, 1, dc, st, who, g, dA, dB, l1, l2, stray, res);
                modelLast = expWho;
                testsRun += 5;
                if (who != expWho || g != expWho) begin
                    testsFailed++; $display("[TB] FAIL rand%0d_%0d_order: got done=%0d gnt=%0d, expected %0d", j, k, who, g, expWho);
                end
                if (res != expRes) begin
                    testsFailed++; $display("[TB] FAIL rand%0d_%0d_result: got %0d, expected %0d", j, k, res, expRes);
                end
                if (dc != ops[expWho][1] + 4) begin
                    testsFailed++; $display("[TB] FAIL rand%0d_%0d_latency: got %0d, expected %0d", j, k, dc, ops[expWho][1] + 4);
                end
                if (st != ops[expWho][1]) begin
                    testsFailed++; $display("[TB] FAIL rand%0d_%0d_strobes: got %0d, expected %0d", j, k, st, ops[expWho][1]);
                end
                if (stray || !l1 || !l2 || dA != ops[expWho][0] || dB != ops[expWho][1]) begin
                    testsFailed++;
                    $display("[TB] FAIL rand%0d_%0d_bus: got lda=%0b ldb=%0b a=%0d b=%0d stray=%0b, expected 1 1 %0d %0d 0",
                             j, k, l1, l2, dA, dB, stray, ops[expWho][0], ops[expWho][1]);
                end
            end
        end
    endtask

    initial begin
        testsRun = 0; testsFailed = 0; modelLast = 1;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        test_reset();
        test_basic();
        test_zero();
        test_simultaneous();
        test_back_to_back();
        test_overflow();
        test_reset_mid_job();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, operand/product width of the shared repeated-addition multiplier datapath.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Ports (name  direction  width  meaning):
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  req0, req1  in  1  level request from requester 0/1
  a0, b0, a1, b1  in  WIDTH  multiplicand/multiplier of requester 0/1
  done0, done1  out  1  one-cycle completion pulse to requester 0/1
  result  out  WIDTH  product of the last completed job, held until the next completion
  busy  out  1  FSM not in IDLE
  gnt_id  out  1  index of the requester being served; valid while busy
  data_out  out  WIDTH  operand bus to the datapath data input
  lda, ldb, ldp, clrp, decb  out  1  datapath strobes: load A, load B, P<=P+A, clear P, B<=B-1
  eqz  in  1  datapath flag: B register == 0, combinational
  p_in  in  WIDTH  datapath product register P

Function
REQ-004 States: IDLE, LDA, LDB, ADD, DONE; all outputs registered or decoded from state, except ldp/decb, which are also gated by eqz.
REQ-005 IDLE: req0/req1 are sampled only here; if any are high, the FSM latches the winner's a/b into internal registers, sets gnt_id, and goes to LDA; otherwise it stays.
REQ-006 Arbitration SHALL be round-robin: on simultaneous requests the requester not served last wins; after reset, requester 0 has priority.
REQ-007 LDA: lda=1, data_out=latched a; next state LDB.
REQ-008 LDB: ldb=1, clrp=1, data_out=latched b; next state ADD.
REQ-009 ADD: if eqz=0, ldp=1 and decb=1 in the same cycle and the FSM stays in ADD; if eqz=1, no strobes, result<=p_in, next state DONE.
REQ-010 DONE: done pulse on the served requester's line for exactly one cycle, with result valid; next state IDLE.
REQ-011 Latency: with LDA counted as cycle 1 after the sampling edge, done is asserted in cycle b+4; there are exactly b ldp/decb strobes; b=0 gives zero strobes and result 0.
REQ-012 Arithmetic SHALL be modulo 2^WIDTH; overflow is silently truncated and has no flag.
REQ-013 Operands SHALL be captured at grant; changes to a/b, or deassertion of req, after grant SHALL NOT affect the job, and done is still pulsed.
REQ-014 A requester SHALL drop req at the edge ending its done cycle; a req still high in the following IDLE cycle is a new job.
REQ-015 Strobes outside their states and data_out in IDLE/ADD/DONE SHALL be 0.
REQ-016 Minimum gap between jobs is one IDLE cycle.

Reset
REQ-017 rst SHALL force, at the next edge from any state: state=IDLE; all strobes, done0, done1 and busy =0; gnt_id=0; result=0; data_out=0; round-robin pointer to favour requester 0.
REQ-018 Reset mid-job SHALL abort without a done pulse; datapath contents are left as-is and are cleared by the next job's clrp.

Structure
REQ-019 Shared package mul_pkg SHALL hold WIDTH and the FSM state encoding; the datapath and the arbiter both use them.
REQ-020 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs: two requests and the last-served bit; outputs: grant valid and grant index). The FSM and the strobe decode stay in mul_arbiter.

Verification
REQ-021 The bench SHALL instantiate mul_arbiter with the existing multiplier datapath and cover:
  1. req0, a0=17, b0=5 -> lda with data_out=17, then ldb/clrp with data_out=5, 5 ldp/decb strobes, done0 in cycle 9, result=85.
  2. req1, a1=9, b1=0 -> no ldp/decb strobes, done1 in cycle 4, result=0.
  3. req0 (3,4) and req1 (6,7) raised together after reset -> req0 served first (result=12, done0), then req1 (result=42, done1); gnt_id 0 then 1.
  4. req0 and req1 both re-requesting continuously for 4 jobs -> service order 0,1,0,1; no requester starves.
  5. a0=300, b0=300 -> result=24464 (90000 mod 65536).
  6. rst pulsed during ADD of a job with b=10 -> all strobes 0 from the next cycle, no done pulse, busy=0; next simultaneous request is granted to requester 0.
